rgb_palette_quantizer: RTL and testbench

RGB_PALETTE_QUANTIZER -- requirements
Module: rgb_palette_quantizer

---
 rtl/rgb_palette_quantizer.sv | 129 ++++++++++++
 tb/tb_rgb_palette_quantizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_palette_quantizer.sv
// Nearest-colour quantizer against a fixed 16-entry 4:4:4 palette.
// Accepts one query, sweeps all 16 entries (one per cycle) using Manhattan
// distance, then holds the winning index/distance until the consumer takes it.
module rgb_palette_quantizer #(
    parameter bit SKIP_KEY = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_index,
    output logic [5:0] out_dist
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    localparam logic [11:0] KeyColour = 12'hF0D;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [11:0] r_query;
    logic [3:0]  r_best_idx;
    logic [5:0]  r_best_dist;
    logic [3:0]  r_out_index;
    logic [5:0]  r_out_dist;

    logic [11:0] w_entry;
    logic [5:0]  w_dist;
    logic        w_eligible;
    logic        w_take;
    logic [3:0]  w_next_idx;
    logic [5:0]  w_next_dist;

    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [11:0] c;
        unique case (idx)
            4'd0:  c = 12'hF0D;
            4'd1:  c = 12'h854;
            4'd2:  c = 12'hCEB;
            4'd3:  c = 12'hEB5;
            4'd4:  c = 12'h323;
            4'd5:  c = 12'h447;
            4'd6:  c = 12'hD72;
            4'd7:  c = 12'hABC;
            4'd8:  c = 12'hB35;
            4'd9:  c = 12'h788;
            4'd10: c = 12'hED7;
            4'd11: c = 12'h623;
            4'd12: c = 12'h435;
            4'd13: c = 12'hD56;
            4'd14: c = 12'h667;
            4'd15: c = 12'hCA5;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {2'b00, d};
    endfunction

    // Evaluate the palette entry selected by the search counter
    always_comb begin
        w_entry = palette(r_cnt);
        w_dist  = abs_diff(r_query[11:8], w_entry[11:8])
                + abs_diff(r_query[7:4],  w_entry[7:4])
                + abs_diff(r_query[3:0],  w_entry[3:0]);
        // The transparency key only competes on an exact hit
        w_eligible  = !(SKIP_KEY && (r_cnt == 4'd0)) || (r_query == KeyColour);
        // Strict less-than keeps the lower index on ties
        w_take      = w_eligible && (w_dist < r_best_dist);
        w_next_idx  = w_take ? r_cnt  : r_best_idx;
        w_next_dist = w_take ? w_dist : r_best_dist;
    end

    // Control FSM with search datapath and registered result
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_query     <= 12'h000;
            r_best_idx  <= 4'd0;
            r_best_dist <= 6'd0;
            r_out_index <= 4'd0;
            r_out_dist  <= 6'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_query     <= {red, green, blue};
                        r_cnt       <= 4'd0;
                        r_best_idx  <= 4'd0;
                        // Above any real distance so the first candidate always wins
                        r_best_dist <= 6'h3F;
                        r_state     <= StSearch;
                    end
                end
                StSearch: begin
                    r_best_idx  <= w_next_idx;
                    r_best_dist <= w_next_dist;
                    r_cnt       <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_out_index <= w_next_idx;
                        r_out_dist  <= w_next_dist;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign out_index = r_out_index;
    assign out_dist  = r_out_dist;

endmodule

// File: tb/tb_rgb_palette_quantizer.sv
// Directed bench for rgb_palette_quantizer: known vectors, backpressure,
// mid-search reset and a back-to-back stream against a reference model.
module tb_rgb_palette_quantizer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] red = 4'h0;
    logic [3:0] green = 4'h0;
    logic [3:0] blue = 4'h0;

    logic       in_ready, out_valid;
    logic [3:0] out_index;
    logic [5:0] out_dist;
    logic       in_ready0, out_valid0;
    logic [3:0] out_index0;
    logic [5:0] out_dist0;

    int checks = 0;
    int failures = 0;

    logic [11:0] pal [0:15] = '{12'hF0D, 12'h854, 12'hCEB, 12'hEB5, 12'h323, 12'h447,
                                12'hD72, 12'hABC, 12'hB35, 12'h788, 12'hED7, 12'h623,
                                12'h435, 12'hD56, 12'h667, 12'hCA5};

    rgb_palette_quantizer #(.SKIP_KEY(1'b1)) u_dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_dist  (out_dist)
    );

    // Same stimulus, key treated as an ordinary entry
    rgb_palette_quantizer #(.SKIP_KEY(1'b0)) u_dut0 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_index (out_index0),
        .out_dist  (out_dist0)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {index[3:0], dist[5:0]}
    function automatic logic [9:0] model(input logic [11:0] q, input bit skip);
        int best_d, best_i, d, x;
        best_d = 1000;
        best_i = 0;
        for (int i = 0; i < 16; i++) begin
            if (!(skip && i == 0 && q != 12'hF0D)) begin
                d = 0;
                for (int s = 0; s < 3; s++) begin
                    x = int'((q >> (4 * s)) & 12'hF) - int'((pal[i] >> (4 * s)) & 12'hF);
                    d += (x < 0) ? -x : x;
                end
                if (d < best_d) begin
                    best_d = d;
                    best_i = i;
                end
            end
        end
        return {4'(best_i), 6'(best_d)};
    endfunction

    // Issue one query from IDLE and wait for out_valid; in_valid is kept high
    // with a different colour during the search to show it is ignored.
    task automatic run_req(input string tag, input logic [11:0] q);
        int lat;
        int bad_ready;
        bad_ready = 0;
        {red, green, blue} = q;
        in_valid = 1'b1;
        #1;
        check({tag, "_accept_ready"}, in_ready, 1);
        @(posedge Clk);
        #1;
        {red, green, blue} = ~q;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) bad_ready++;
            @(posedge Clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_ready_low"}, bad_ready, 0);
        // Accept edge counted as edge 1, out_valid after the 17th edge
        check({tag, "_latency"}, lat, 16);
    endtask

    task automatic take_result(input string tag, input int exp_idx, input int exp_dist);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_index"}, out_index, exp_idx);
        check({tag, "_dist"}, out_dist, exp_dist);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_back_idle"}, in_ready, 1);
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [9:0]  e;
        logic [11:0] cur;
        logic [9:0]  exp_q[$];
        int          cyc, last, n_acc, n_res, spurious;
        bit          accepted;

        // Reset values
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_index", out_index, 0);
        check("rst_dist", out_dist, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // First accept on the first edge out of reset
        run_req("key_exact", 12'hF0D);
        check("key_exact_nokey_idx", out_index0, 0);
        check("key_exact_nokey_dist", out_dist0, 0);
        take_result("key_exact", 0, 0);

        run_req("exact_1", 12'h854);
        take_result("exact_1", 1, 0);

        run_req("black", 12'h000);
        take_result("black", 4, 8);

        run_req("white", 12'hFFF);
        take_result("white", 2, 8);

        run_req("tie_777", 12'h777);
        take_result("tie_777", 9, 2);

        run_req("key_excl", 12'hF0E);
        check("key_ordinary_idx", out_index0, 0);
        check("key_ordinary_dist", out_dist0, 1);
        take_result("key_excl", 13, 15);

        // Backpressure: result must hold while out_ready is low
        run_req("bp", 12'h435);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            check("bp_valid_hold", out_valid, 1);
            check("bp_index_hold", out_index, 12);
            check("bp_dist_hold", out_dist, 0);
            check("bp_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_ready", in_ready, 1);

        // Reset while the counter sits at entry 7
        {red, green, blue} = 12'hCA5;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_index", out_index, 0);
        check("midrst_dist", out_dist, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk);
            #1;
            if (out_valid !== 1'b0) spurious++;
        end
        check("midrst_no_valid", spurious, 0);
        check("midrst_still_idle", in_ready, 1);
        run_req("after_rst", 12'h623);
        take_result("after_rst", 11, 0);

        // Back-to-back stream against the reference model
        cyc = 0;
        last = -1;
        n_acc = 0;
        n_res = 0;
        cur = 12'($urandom);
        {red, green, blue} = cur;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (n_res < 20 && cyc < 2000) begin
            @(negedge Clk);
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                check("b2b_index", out_index, e[9:6]);
                check("b2b_dist", out_dist, e[5:0]);
                n_res++;
            end
            accepted = 1'b0;
            if (in_ready && in_valid) begin
                if (last >= 0) check("b2b_interval", cyc - last, 18);
                last = cyc;
                exp_q.push_back(model(cur, 1'b1));
                n_acc++;
                accepted = 1'b1;
            end
            @(posedge Clk);
            cyc++;
            #1;
            if (accepted) begin
                cur = 12'($urandom);
                {red, green, blue} = cur;
            end
            if (n_acc >= 20) in_valid = 1'b0;
        end
        check("b2b_results", n_res, 20);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
